// File: rtl/hack_pkg.sv
// ---------------------------------------------------------------------------
// hack_pkg
// Shared definitions for the Hack gate library.
//   WORD_W : width of a Hack machine word (16 bits)
//   word_t : one Hack word, bit 15 is the MSB
// ---------------------------------------------------------------------------
package hack_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

endpackage : hack_pkg

// File: rtl/not_gate.sv
// ---------------------------------------------------------------------------
// not_gate
// Single-bit Hack primitive inverter.
// Ports:
//   in  : input bit
//   out : complement of in, purely combinational
// ---------------------------------------------------------------------------
module not_gate (
    input  logic in,
    output logic out
);

    assign out = ~in;

endmodule : not_gate

// File: rtl/not16_gate.sv
// ---------------------------------------------------------------------------
// not16_gate
// 16-bit bitwise inverter of the Hack gate library. It offers two outputs:
//   - a zero-latency combinational result
//   - a registered copy of that result for pipelined users
// Ports:
//   in      : data word to invert
//   out     : combinational result, out = ~in (independent of clk and reset)
//   clk     : rising-edge clock, used only by the registered path
//   reset   : synchronous, active-high; clears out_q and out_vld
//   in_vld  : qualifies in for the registered path
//   out_q   : inverted value of the last qualified word
//   out_vld : high for exactly the cycle after an accepted in_vld
// Combinational users may bind only (in, out) positionally and leave the
// clocked ports unconnected.
// ---------------------------------------------------------------------------
module not16_gate
    import hack_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    input  logic             clk,
    input  logic             reset,
    input  logic             in_vld,
    output logic [WIDTH-1:0] out_q,
    output logic             out_vld
);

    // Build the word inverter from one Hack primitive per bit. Bit i only
    // ever feeds bit i, so no reordering can occur.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        not_gate u_not (
            .in  (in[i]),
            .out (out[i])
        );
    end

    // Registered stage fed from the combinational result. Reset takes
    // priority, so a word presented during reset is dropped. Without
    // in_vld the stored word is kept but the valid flag falls.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= '0;
            out_vld <= 1'b0;
        end else begin
            out_vld <= in_vld;
            if (in_vld) begin
                out_q <= out;
            end
        end
    end

endmodule : not16_gate

// File: tb/tb_not16_gate.sv
// ---------------------------------------------------------------------------
// tb_not16_gate
// Self-checking bench for not16_gate: directed combinational, per-bit,
// reset and pipeline steps followed by a randomized run against a
// behavioural reference model of the inverter and its one-cycle register.
// ---------------------------------------------------------------------------
module tb_not16_gate;

    import hack_pkg::*;

    word_t in;
    word_t out;
    logic  clk;
    logic  reset;
    logic  in_vld;
    word_t out_q;
    logic  out_vld;

    int checkCount;
    int passCount;

    // Reference model state for the registered path.
    word_t refQ;
    logic  refVld;

    not16_gate #(.WIDTH(WORD_W)) dut (
        .in      (in),
        .out     (out),
        .clk     (clk),
        .reset   (reset),
        .in_vld  (in_vld),
        .out_q   (out_q),
        .out_vld (out_vld)
    );

    // 10 ns clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inverting a 16-bit word is subtracting it from all-ones.
    function automatic word_t invertRef(input word_t w);
        return word_t'(17'h0FFFF - {1'b0, w});
    endfunction

    // Drive the inputs away from the clock edge.
    task automatic applyStimulus(input word_t w, input logic vld, input logic rst);
        in     = w;
        in_vld = vld;
        reset  = rst;
    endtask

    // One counted comparison.
    task automatic checkOutput(input string tag, input word_t observed, input word_t expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    // Advance to just after the next rising edge and update the model
    // with the inputs that were present at that edge.
    task automatic clockStep();
        logic  r;
        logic  v;
        word_t w;
        r = reset;
        v = in_vld;
        w = in;
        @(posedge clk);
        if (r) begin
            refQ   = '0;
            refVld = 1'b0;
        end else begin
            if (v) refQ = invertRef(w);
            refVld = v;
        end
        #1;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        refQ       = '0;
        refVld     = 1'b0;

        // Reset held for two edges; combinational path keeps working.
        applyStimulus(16'h1234, 1'b0, 1'b1);
        clockStep();
        clockStep();
        checkOutput("reset_out_q", out_q, 16'h0000);
        checkOutput("reset_out_vld", {15'b0, out_vld}, 16'h0000);
        checkOutput("reset_out_comb", out, 16'hEDCB);

        // Combinational sweep.
        applyStimulus(16'h0000, 1'b0, 1'b0);
        #10 checkOutput("comb_0000", out, 16'hFFFF);
        applyStimulus(16'hFFFF, 1'b0, 1'b0);
        #10 checkOutput("comb_FFFF", out, 16'h0000);
        applyStimulus(16'hAAAA, 1'b0, 1'b0);
        #10 checkOutput("comb_AAAA", out, 16'h5555);
        applyStimulus(16'h5555, 1'b0, 1'b0);
        #10 checkOutput("comb_5555", out, 16'hAAAA);
        applyStimulus(16'h1234, 1'b0, 1'b0);
        #10 checkOutput("comb_1234", out, 16'hEDCB);

        // Walking one: each bit inverts independently and in place.
        for (int k = 0; k < 16; k++) begin
            applyStimulus(word_t'(1) << k, 1'b0, 1'b0);
            #1 checkOutput($sformatf("walk_bit%0d", k), out, invertRef(word_t'(1) << k));
        end

        // Back-to-back pipeline words, then drop in_vld.
        clockStep();
        applyStimulus(16'h1234, 1'b1, 1'b0);
        clockStep();
        checkOutput("pipe1_out_q", out_q, 16'hEDCB);
        checkOutput("pipe1_out_vld", {15'b0, out_vld}, 16'h0001);
        applyStimulus(16'h00FF, 1'b1, 1'b0);
        clockStep();
        checkOutput("pipe2_out_q", out_q, 16'hFF00);
        checkOutput("pipe2_out_vld", {15'b0, out_vld}, 16'h0001);
        applyStimulus(16'hAAAA, 1'b0, 1'b0);
        clockStep();
        checkOutput("hold_out_q", out_q, 16'hFF00);
        checkOutput("hold_out_vld", {15'b0, out_vld}, 16'h0000);

        // Reset beats a simultaneous in_vld, then capture resumes.
        applyStimulus(16'h0000, 1'b1, 1'b1);
        clockStep();
        checkOutput("rst_win_out_q", out_q, 16'h0000);
        checkOutput("rst_win_out_vld", {15'b0, out_vld}, 16'h0000);
        applyStimulus(16'h0000, 1'b1, 1'b0);
        clockStep();
        checkOutput("post_rst_out_q", out_q, 16'hFFFF);
        checkOutput("post_rst_out_vld", {15'b0, out_vld}, 16'h0001);

        // Randomized run against the reference model, with rare resets.
        for (int n = 0; n < 1000; n++) begin
            applyStimulus(word_t'($urandom), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 49) == 0));
            #1 checkOutput("rand_out", out, invertRef(in));
            clockStep();
            checkOutput("rand_out_q", out_q, refQ);
            checkOutput("rand_out_vld", {15'b0, out_vld}, {15'b0, refVld});
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule : tb_not16_gate
